neuron_cfg_loader: RTL and testbench

Streams weights and biases from a host word stream into a layer of neurons over the neuron configuration bus (`weightValid`/`weightValue`, `biasValid`/`biasValue`, `config_layer_num`/`config_neuron_num`). It sits between the AXI-side register/stream front end and the neuron array of one layer. It acts as the bus transmitter: it sequences neuron indices, tags every word with layer/neuron numbers and signals completion.

---
 rtl/neuron_cfg_loader_pkg.sv | 23 ++
 rtl/neuron_cfg_loader.sv | 153 +++++++++++++++
 tb/tb_neuron_cfg_loader.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_cfg_loader_pkg.sv
// rtl/neuron_cfg_loader_pkg.sv - shared types and width helpers for the neuron config loader
package neuron_cfg_loader_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int CFG_W_DEF      = 2 * DATA_WIDTH_DEF + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WEIGHT = 2'd1,
        ST_BIAS   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic int cfg_w(input int data_width);
        return 2 * data_width + 1;
    endfunction

    // Single-entry counts still need a 1-bit register.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/neuron_cfg_loader.sv
// rtl/neuron_cfg_loader.sv - streams host words into one layer's neurons as tagged weight/bias strobes
module neuron_cfg_loader
    import neuron_cfg_loader_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int LAYER_NO    = 1,
    parameter int NUM_NEURONS = 30,
    parameter int NUM_WEIGHT  = 128
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          s_valid,
    input  logic [DATA_WIDTH-1:0]         s_data,
    output logic                          s_ready,
    output logic                          weightValid,
    output logic [DATA_WIDTH-1:0]         weightValue,
    output logic                          biasValid,
    output logic [DATA_WIDTH-1:0]         biasValue,
    output logic [2*DATA_WIDTH:0]         config_layer_num,
    output logic [2*DATA_WIDTH:0]         config_neuron_num,
    output logic                          busy,
    output logic                          done
);

    localparam int CFG_W = cfg_w(DATA_WIDTH);
    localparam int WCW   = cnt_w(NUM_WEIGHT);
    localparam int NCW   = cnt_w(NUM_NEURONS);

    localparam logic [WCW-1:0]   W_LAST    = WCW'(NUM_WEIGHT - 1);
    localparam logic [NCW-1:0]   N_LAST    = NCW'(NUM_NEURONS - 1);
    localparam logic [CFG_W-1:0] LAYER_VAL = CFG_W'(LAYER_NO);

    state_e                state_q, state_d;
    logic [WCW-1:0]        weight_cnt_q, weight_cnt_d;
    logic [NCW-1:0]        neuron_cnt_q, neuron_cnt_d;
    logic                  weight_valid_q, weight_valid_d;
    logic                  bias_valid_q, bias_valid_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] weight_value_q, weight_value_d;
    logic [DATA_WIDTH-1:0] bias_value_q, bias_value_d;
    logic [CFG_W-1:0]      layer_num_q, layer_num_d;
    logic [CFG_W-1:0]      neuron_num_q, neuron_num_d;

    logic busy_w;
    logic hs;

    assign busy_w = (state_q == ST_WEIGHT) || (state_q == ST_BIAS);
    // Abort wins over a word offered in the same cycle.
    assign hs     = s_valid & busy_w & ~abort;

    always_comb begin
        state_d        = state_q;
        weight_cnt_d   = weight_cnt_q;
        neuron_cnt_d   = neuron_cnt_q;
        weight_valid_d = 1'b0;
        bias_valid_d   = 1'b0;
        done_d         = 1'b0;
        weight_value_d = weight_value_q;
        bias_value_d   = bias_value_q;
        neuron_num_d   = neuron_num_q;

        if (abort) begin
            state_d      = ST_IDLE;
            weight_cnt_d = '0;
            neuron_cnt_d = '0;
            neuron_num_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d      = ST_WEIGHT;
                        weight_cnt_d = '0;
                        neuron_cnt_d = '0;
                    end
                end
                ST_WEIGHT: begin
                    if (hs) begin
                        weight_valid_d = 1'b1;
                        weight_value_d = s_data;
                        neuron_num_d   = CFG_W'(neuron_cnt_q);
                        if (weight_cnt_q == W_LAST) begin
                            state_d = ST_BIAS;
                        end else begin
                            weight_cnt_d = weight_cnt_q + 1'b1;
                        end
                    end
                end
                ST_BIAS: begin
                    if (hs) begin
                        bias_valid_d = 1'b1;
                        bias_value_d = s_data;
                        neuron_num_d = CFG_W'(neuron_cnt_q);
                        if (neuron_cnt_q == N_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            neuron_cnt_d = neuron_cnt_q + 1'b1;
                            weight_cnt_d = '0;
                            state_d      = ST_WEIGHT;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // The last bias strobe lands in DONE, so the layer tag also follows the strobes.
        layer_num_d = ((state_d == ST_WEIGHT) || (state_d == ST_BIAS) ||
                       weight_valid_d || bias_valid_d) ? LAYER_VAL : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            weight_cnt_q   <= '0;
            neuron_cnt_q   <= '0;
            weight_valid_q <= 1'b0;
            bias_valid_q   <= 1'b0;
            done_q         <= 1'b0;
            weight_value_q <= '0;
            bias_value_q   <= '0;
            layer_num_q    <= '0;
            neuron_num_q   <= '0;
        end else begin
            state_q        <= state_d;
            weight_cnt_q   <= weight_cnt_d;
            neuron_cnt_q   <= neuron_cnt_d;
            weight_valid_q <= weight_valid_d;
            bias_valid_q   <= bias_valid_d;
            done_q         <= done_d;
            weight_value_q <= weight_value_d;
            bias_value_q   <= bias_value_d;
            layer_num_q    <= layer_num_d;
            neuron_num_q   <= neuron_num_d;
        end
    end

    assign s_ready           = busy_w;
    assign busy              = busy_w;
    assign done              = done_q;
    assign weightValid       = weight_valid_q;
    assign weightValue       = weight_value_q;
    assign biasValid         = bias_valid_q;
    assign biasValue         = bias_value_q;
    assign config_layer_num  = layer_num_q;
    assign config_neuron_num = neuron_num_q;

endmodule

// File: tb/tb_neuron_cfg_loader.sv
// tb/tb_neuron_cfg_loader.sv - self-checking bench for neuron_cfg_loader with a word-order reference model
module tb_neuron_cfg_loader;

    localparam int DW      = 16;
    localparam int NW      = 4;
    localparam int NN      = 2;
    localparam int LAYER   = 1;
    localparam int CW      = 2 * DW + 1;
    localparam int RUN_LEN = NN * (NW + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          weightValid;
    logic [DW-1:0] weightValue;
    logic          biasValid;
    logic [DW-1:0] biasValue;
    logic [CW-1:0] config_layer_num;
    logic [CW-1:0] config_neuron_num;
    logic          busy;
    logic          done;

    typedef struct {
        bit            is_bias;
        logic [DW-1:0] val;
        logic [CW-1:0] nrn;
        logic [CW-1:0] lay;
        int            cyc;
    } ev_t;

    ev_t           ev_q[$];
    int            done_cyc[$];
    logic [DW-1:0] sent_q[$];
    int            cyc     = 0;
    int            nchecks = 0;
    int            nerr    = 0;

    neuron_cfg_loader #(
        .DATA_WIDTH (DW),
        .LAYER_NO   (LAYER),
        .NUM_NEURONS(NN),
        .NUM_WEIGHT (NW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .s_valid          (s_valid),
        .s_data           (s_data),
        .s_ready          (s_ready),
        .weightValid      (weightValid),
        .weightValue      (weightValue),
        .biasValid        (biasValid),
        .biasValue        (biasValue),
        .config_layer_num (config_layer_num),
        .config_neuron_num(config_neuron_num),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (weightValid || biasValid)
            ev_q.push_back('{biasValid, biasValid ? biasValue : weightValue,
                             config_neuron_num, config_layer_num, cyc});
        if (done)
            done_cyc.push_back(cyc);
    end

    // Word k of a run: neuron k/(NW+1); the last word of each group is the bias.
    function automatic ev_t model_ev(input int k, input logic [DW-1:0] v);
        ev_t e;
        e.is_bias = ((k % (NW + 1)) == NW);
        e.val     = v;
        e.nrn     = CW'(k / (NW + 1));
        e.lay     = CW'(LAYER);
        e.cyc     = 0;
        return e;
    endfunction

    task automatic clear_obs();
        ev_q.delete();
        done_cyc.delete();
        sent_q.delete();
    endtask

    task automatic stream_words(input int n, input int gap_pct, input bit seq,
                                input int start_at, input bit start_in_done);
        logic [DW-1:0] w;
        int i;
        int stalls;
        i      = 0;
        stalls = 0;
        w      = seq ? DW'(1) : DW'($urandom);
        while (i < n) begin
            @(negedge clk);
            start   = (i == start_at);
            s_valid = ($urandom_range(0, 99) >= gap_pct);
            s_data  = w;
            if (s_valid && s_ready) begin
                sent_q.push_back(w);
                i      = i + 1;
                stalls = 0;
                w      = seq ? DW'(i + 1) : DW'($urandom);
            end else if (s_valid) begin
                stalls = stalls + 1;
                if (stalls > 20) begin
                    nchecks++;
                    nerr++;
                    $display("FAIL stream_stall word=%0d s_ready=%0b required 1", i, s_ready);
                    break;
                end
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        start   = start_in_done;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        #2;
        nchecks++;
        if ({s_ready, weightValid, biasValid, busy, done, weightValue, biasValue,
             config_layer_num, config_neuron_num} !== '0) begin
            nerr++;
            $display("FAIL reset_init outputs not all zero: ready=%0b wv=%0b bv=%0b busy=%0b done=%0b",
                     s_ready, weightValid, biasValid, busy, done);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; s_valid = 1'b1; s_data = 16'h1234;
        for (int t = 0; t < 10 && !weightValid; t++) @(negedge clk);
        nchecks++;
        if (weightValid !== 1'b1) begin
            nerr++;
            $display("FAIL reset_wait weightValid=%0b required 1", weightValid);
        end
        rst_n = 1'b0;
        #1;
        nchecks++;
        if ({s_ready, weightValid, biasValid, busy, done, weightValue, biasValue,
             config_layer_num, config_neuron_num} !== '0) begin
            nerr++;
            $display("FAIL reset_async outputs not zero: ready=%0b wv=%0b val=%h nrn=%0d lay=%0d",
                     s_ready, weightValid, weightValue, config_neuron_num, config_layer_num);
        end
        @(negedge clk); rst_n = 1'b1;
        clear_obs();
        repeat (3) @(negedge clk);
        nchecks++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || ev_q.size() != 0) begin
            nerr++;
            $display("FAIL reset_idle busy=%0b s_ready=%0b strobes=%0d required 0 0 0",
                     busy, s_ready, ev_q.size());
        end
        s_valid = 1'b0;
    endtask

    task automatic test_stray_data();
        clear_obs();
        s_valid = 1'b1;
        s_data  = 16'h7FFF;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            nchecks++;
            if (s_ready !== 1'b0) begin
                nerr++;
                $display("FAIL stray_ready cycle=%0d s_ready=%0b required 0", t, s_ready);
            end
        end
        s_valid = 1'b0;
        @(negedge clk);
        nchecks++;
        if (ev_q.size() != 0) begin
            nerr++;
            $display("FAIL stray_strobe count=%0d required 0", ev_q.size());
        end
    endtask

    task automatic test_full_run();
        ev_t e;
        clear_obs();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        nchecks++;
        if (s_ready !== 1'b1) begin
            nerr++;
            $display("FAIL full_ready_after_start s_ready=%0b required 1", s_ready);
        end
        stream_words(RUN_LEN, 0, 1'b1, -1, 1'b0);
        repeat (4) @(negedge clk);
        for (int k = 0; k < RUN_LEN; k++) begin
            e = model_ev(k, DW'(k + 1));
            nchecks++;
            if (k >= ev_q.size()) begin
                nerr++;
                $display("FAIL full_ev%0d missing, got %0d strobes required %0d", k, ev_q.size(), RUN_LEN);
            end else if (ev_q[k].is_bias !== e.is_bias || ev_q[k].val !== e.val ||
                         ev_q[k].nrn !== e.nrn || ev_q[k].lay !== e.lay) begin
                nerr++;
                $display("FAIL full_ev%0d got bias=%0b val=%0d nrn=%0d lay=%0d required bias=%0b val=%0d nrn=%0d lay=%0d",
                         k, ev_q[k].is_bias, ev_q[k].val, ev_q[k].nrn, ev_q[k].lay,
                         e.is_bias, e.val, e.nrn, e.lay);
            end
        end
        nchecks++;
        if (ev_q.size() != RUN_LEN || ev_q[RUN_LEN-1].cyc - ev_q[0].cyc != RUN_LEN - 1) begin
            nerr++;
            $display("FAIL full_no_bubble strobes=%0d span=%0d required %0d %0d", ev_q.size(),
                     (ev_q.size() > 0) ? ev_q[$].cyc - ev_q[0].cyc : -1, RUN_LEN, RUN_LEN - 1);
        end
        nchecks++;
        if (done_cyc.size() != 1) begin
            nerr++;
            $display("FAIL full_done_count got %0d required 1", done_cyc.size());
        end else if (ev_q.size() == 0 || done_cyc[0] != ev_q[$].cyc + 1) begin
            nerr++;
            $display("FAIL full_done_timing got cycle %0d required %0d", done_cyc[0],
                     (ev_q.size() > 0) ? ev_q[$].cyc + 1 : -1);
        end
    endtask

    task automatic test_backpressure();
        ev_t e;
        clear_obs();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        stream_words(RUN_LEN, 40, 1'b0, -1, 1'b0);
        repeat (4) @(negedge clk);
        for (int k = 0; k < sent_q.size(); k++) begin
            e = model_ev(k, sent_q[k]);
            nchecks++;
            if (k >= ev_q.size()) begin
                nerr++;
                $display("FAIL bp_ev%0d missing, got %0d strobes", k, ev_q.size());
            end else if (ev_q[k].is_bias !== e.is_bias || ev_q[k].val !== e.val ||
                         ev_q[k].nrn !== e.nrn || ev_q[k].lay !== e.lay) begin
                nerr++;
                $display("FAIL bp_ev%0d got bias=%0b val=%h nrn=%0d lay=%0d required bias=%0b val=%h nrn=%0d lay=%0d",
                         k, ev_q[k].is_bias, ev_q[k].val, ev_q[k].nrn, ev_q[k].lay,
                         e.is_bias, e.val, e.nrn, e.lay);
            end
        end
        nchecks++;
        if (ev_q.size() != RUN_LEN || sent_q.size() != RUN_LEN) begin
            nerr++;
            $display("FAIL bp_count strobes=%0d sent=%0d required %0d", ev_q.size(), sent_q.size(), RUN_LEN);
        end
        nchecks++;
        if (done_cyc.size() != 1 || ev_q.size() == 0 || done_cyc[0] != ev_q[$].cyc + 1) begin
            nerr++;
            $display("FAIL bp_done count=%0d required 1 after last strobe", done_cyc.size());
        end
    endtask

    task automatic test_illegal_start();
        ev_t e;
        clear_obs();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        stream_words(RUN_LEN, 20, 1'b0, 3, 1'b1);
        s_valid = 1'b1;
        s_data  = 16'h7FFF;
        repeat (8) @(negedge clk);
        s_valid = 1'b0;
        for (int k = 0; k < RUN_LEN; k++) begin
            e = model_ev(k, (k < sent_q.size()) ? sent_q[k] : '0);
            nchecks++;
            if (k >= ev_q.size()) begin
                nerr++;
                $display("FAIL ill_ev%0d missing, got %0d strobes", k, ev_q.size());
            end else if (ev_q[k].is_bias !== e.is_bias || ev_q[k].val !== e.val ||
                         ev_q[k].nrn !== e.nrn) begin
                nerr++;
                $display("FAIL ill_ev%0d got bias=%0b val=%h nrn=%0d required bias=%0b val=%h nrn=%0d",
                         k, ev_q[k].is_bias, ev_q[k].val, ev_q[k].nrn, e.is_bias, e.val, e.nrn);
            end
        end
        nchecks++;
        if (ev_q.size() != RUN_LEN || done_cyc.size() != 1) begin
            nerr++;
            $display("FAIL ill_extra_run strobes=%0d dones=%0d required %0d 1",
                     ev_q.size(), done_cyc.size(), RUN_LEN);
        end
    endtask

    task automatic test_abort();
        int nw;
        int stray;
        nw    = 0;
        stray = 0;
        clear_obs();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; s_valid = 1'b1; s_data = 16'd1;
        for (int t = 0; t < 20 && nw < 3; t++) begin
            @(negedge clk);
            if (weightValid) nw++;
            if (nw < 3) s_data = s_data + 1'b1;
        end
        nchecks++;
        if (nw != 3) begin
            nerr++;
            $display("FAIL abort_wait weights=%0d required 3", nw);
        end
        s_data = 16'h7FFF;
        abort  = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        nchecks++;
        if (busy !== 1'b0 || weightValid !== 1'b0 || biasValid !== 1'b0) begin
            nerr++;
            $display("FAIL abort_next busy=%0b wv=%0b bv=%0b required 0 0 0", busy, weightValid, biasValid);
        end
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            if (weightValid || biasValid || s_ready) stray++;
        end
        nchecks++;
        if (stray != 0) begin
            nerr++;
            $display("FAIL abort_quiet active_cycles=%0d required 0", stray);
        end
        s_valid = 1'b0;
        clear_obs();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        stream_words(RUN_LEN, 0, 1'b1, -1, 1'b0);
        repeat (3) @(negedge clk);
        nchecks++;
        if (ev_q.size() != RUN_LEN || done_cyc.size() != 1) begin
            nerr++;
            $display("FAIL abort_rerun_count strobes=%0d dones=%0d required %0d 1",
                     ev_q.size(), done_cyc.size(), RUN_LEN);
        end else if (ev_q[0].is_bias !== 1'b0 || ev_q[0].nrn !== '0 || ev_q[0].val !== 16'd1 ||
                     ev_q[NW].is_bias !== 1'b1 || ev_q[NW].nrn !== '0) begin
            nerr++;
            $display("FAIL abort_rerun_start first bias=%0b nrn=%0d val=%0d required 0 0 1",
                     ev_q[0].is_bias, ev_q[0].nrn, ev_q[0].val);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stray_data();
        test_full_run();
        test_backpressure();
        test_illegal_start();
        test_abort();
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
